// File: rtl/can_tx_mailbox_arbiter.sv
// Transmit mailbox arbiter: holds NUM_MB software-loaded CAN frames and feeds the
// lowest-ID pending frame to a single CAN transmit engine.
module can_tx_mailbox_arbiter #(
    parameter int unsigned NUM_MB       = 4,
    parameter int unsigned MB_W         = 2,
    parameter int unsigned BUSY_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mb_wr_en,
    input  logic [MB_W-1:0]   mb_wr_sel,
    input  logic [10:0]       mb_wr_id,
    input  logic [7:0]        mb_wr_data,
    input  logic [NUM_MB-1:0] mb_abort,
    output logic [NUM_MB-1:0] mb_pending,
    output logic [NUM_MB-1:0] mb_done,
    output logic              wr_err,
    output logic              timeout,
    output logic [10:0]       can_id,
    output logic [7:0]        can_data,
    output logic              can_send,
    input  logic              can_busy,
    output logic [MB_W-1:0]   cur_mb,
    output logic              arb_active
);

    localparam int unsigned CntW = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [2:0] {
        StIdle,
        StSelect,
        StLaunch,
        StWaitBusy,
        StWaitDone
    } state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [MB_W-1:0]     cur_mb_q, cur_mb_d;
    logic [10:0]         can_id_q, can_id_d;
    logic [7:0]          can_data_q, can_data_d;
    logic [NUM_MB-1:0]   pending_q, pending_d;
    logic [NUM_MB-1:0]   done_q, done_d;
    logic                timeout_q, timeout_d;
    logic                wr_err_q, wr_err_d;
    logic [10:0]         id_q [NUM_MB];
    logic [10:0]         id_d [NUM_MB];
    logic [7:0]          data_q [NUM_MB];
    logic [7:0]          data_d [NUM_MB];

    logic                locked;
    logic [NUM_MB-1:0]   lock_mask;
    logic [NUM_MB-1:0]   abort_eff;
    logic                wr_ok;
    logic                found;
    logic [MB_W-1:0]     win_idx;
    logic [10:0]         win_id;

    // The in-flight mailbox is immune to writes and aborts until its frame finishes.
    always_comb begin
        locked    = (state_q == StLaunch) || (state_q == StWaitBusy) || (state_q == StWaitDone);
        lock_mask = '0;
        for (int unsigned i = 0; i < NUM_MB; i++) begin
            if (locked && (cur_mb_q == MB_W'(i))) begin
                lock_mask[i] = 1'b1;
            end
        end
        abort_eff = mb_abort & ~lock_mask;
        wr_err_d  = mb_wr_en && locked && (mb_wr_sel == cur_mb_q);
        wr_ok     = mb_wr_en && !wr_err_d;
    end

    // Strict less-than while scanning upward keeps the lowest index on equal IDs.
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        win_id  = '0;
        for (int unsigned i = 0; i < NUM_MB; i++) begin
            if (pending_q[i] && !abort_eff[i] && (!found || (id_q[i] < win_id))) begin
                found   = 1'b1;
                win_idx = MB_W'(i);
                win_id  = id_q[i];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cur_mb_d   = cur_mb_q;
        can_id_d   = can_id_q;
        can_data_d = can_data_q;
        done_d     = '0;
        timeout_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (|pending_q) begin
                    state_d = StSelect;
                end
            end
            StSelect: begin
                if (!found) begin
                    state_d = StIdle;
                end else begin
                    cur_mb_d   = win_idx;
                    can_id_d   = win_id;
                    can_data_d = data_q[win_idx];
                    // Hold off the launch while the engine still reports busy.
                    if (!can_busy) begin
                        state_d = StLaunch;
                    end
                end
            end
            StLaunch: begin
                cnt_d   = '0;
                state_d = StWaitBusy;
            end
            StWaitBusy: begin
                if (can_busy) begin
                    state_d = StWaitDone;
                end else if (cnt_q == CntW'(BUSY_TIMEOUT - 1)) begin
                    cnt_d     = cnt_q + CntW'(1);
                    timeout_d = 1'b1;
                    state_d   = StIdle;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StWaitDone: begin
                if (!can_busy) begin
                    for (int unsigned i = 0; i < NUM_MB; i++) begin
                        if (cur_mb_q == MB_W'(i)) begin
                            done_d[i] = 1'b1;
                        end
                    end
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // A same-cycle write beats an abort on the same unlocked mailbox.
    always_comb begin
        pending_d = pending_q & ~abort_eff & ~done_d;
        for (int unsigned i = 0; i < NUM_MB; i++) begin
            id_d[i]   = id_q[i];
            data_d[i] = data_q[i];
            if (wr_ok && (mb_wr_sel == MB_W'(i))) begin
                pending_d[i] = 1'b1;
                id_d[i]      = mb_wr_id;
                data_d[i]    = mb_wr_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            cur_mb_q   <= '0;
            can_id_q   <= '0;
            can_data_q <= '0;
            pending_q  <= '0;
            done_q     <= '0;
            timeout_q  <= 1'b0;
            wr_err_q   <= 1'b0;
            for (int unsigned i = 0; i < NUM_MB; i++) begin
                id_q[i]   <= '0;
                data_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cur_mb_q   <= cur_mb_d;
            can_id_q   <= can_id_d;
            can_data_q <= can_data_d;
            pending_q  <= pending_d;
            done_q     <= done_d;
            timeout_q  <= timeout_d;
            wr_err_q   <= wr_err_d;
            for (int unsigned i = 0; i < NUM_MB; i++) begin
                id_q[i]   <= id_d[i];
                data_q[i] <= data_d[i];
            end
        end
    end

    assign mb_pending = pending_q;
    assign mb_done    = done_q;
    assign wr_err     = wr_err_q;
    assign timeout    = timeout_q;
    assign can_id     = can_id_q;
    assign can_data   = can_data_q;
    assign can_send   = (state_q == StLaunch);
    assign cur_mb     = cur_mb_q;
    assign arb_active = (state_q != StIdle);

endmodule

// File: tb/tb_can_tx_mailbox_arbiter.sv
// Directed bench for can_tx_mailbox_arbiter with a simple busy-pulse engine model.
module tb_can_tx_mailbox_arbiter;

    localparam int NUM_MB = 4;
    localparam int MB_W   = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              mb_wr_en = 1'b0;
    logic [MB_W-1:0]   mb_wr_sel = '0;
    logic [10:0]       mb_wr_id = '0;
    logic [7:0]        mb_wr_data = '0;
    logic [NUM_MB-1:0] mb_abort = '0;
    logic [NUM_MB-1:0] mb_pending;
    logic [NUM_MB-1:0] mb_done;
    logic              wr_err;
    logic              timeout;
    logic [10:0]       can_id;
    logic [7:0]        can_data;
    logic              can_send;
    logic              can_busy = 1'b0;
    logic [MB_W-1:0]   cur_mb;
    logic              arb_active;

    can_tx_mailbox_arbiter #(
        .NUM_MB(NUM_MB),
        .MB_W(MB_W),
        .BUSY_TIMEOUT(15)
    ) dut (
        .clk(clk),
        .rst(rst),
        .mb_wr_en(mb_wr_en),
        .mb_wr_sel(mb_wr_sel),
        .mb_wr_id(mb_wr_id),
        .mb_wr_data(mb_wr_data),
        .mb_abort(mb_abort),
        .mb_pending(mb_pending),
        .mb_done(mb_done),
        .wr_err(wr_err),
        .timeout(timeout),
        .can_id(can_id),
        .can_data(can_data),
        .can_send(can_send),
        .can_busy(can_busy),
        .cur_mb(cur_mb),
        .arb_active(arb_active)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    int          send_cyc[$];
    logic [31:0] send_id[$];
    logic [31:0] send_data[$];
    logic [31:0] send_mb[$];
    int          done_cyc[$];
    logic [31:0] done_vec[$];
    int          to_cyc[$];
    logic [31:0] to_pend[$];
    int          wr_err_cnt = 0;
    int          stab_err = 0;
    int          bad_send = 0;
    logic [10:0] ref_id;
    logic [7:0]  ref_data;
    bit          tracking = 0;
    bit          send_seen = 0;
    bit          model_en = 1;
    int          busy_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitor: logs launches, completions, timeouts and id/data stability.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            tracking = 0;
        end else begin
            if (can_send) begin
                send_cyc.push_back(cyc);
                send_id.push_back(32'(can_id));
                send_data.push_back(32'(can_data));
                send_mb.push_back(32'(cur_mb));
                if (can_busy) bad_send++;
                tracking = 1;
                ref_id   = can_id;
                ref_data = can_data;
            end else if (tracking) begin
                if (!arb_active) tracking = 0;
                else if (can_id !== ref_id || can_data !== ref_data) stab_err++;
            end
            if (|mb_done) begin
                done_cyc.push_back(cyc);
                done_vec.push_back(32'(mb_done));
            end
            if (timeout) begin
                to_cyc.push_back(cyc);
                to_pend.push_back(32'(mb_pending));
            end
            if (wr_err) wr_err_cnt++;
        end
        send_seen = can_send;
    end

    // Engine model: busy rises the cycle after send and stays high for 40 cycles.
    initial forever begin
        @(posedge clk);
        cyc++;
        #1;
        if (send_seen && model_en) begin
            busy_cnt = 40;
            can_busy = 1'b1;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) can_busy = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input int sel, input logic [10:0] id, input logic [7:0] d, output int wcyc);
        mb_wr_en   = 1'b1;
        mb_wr_sel  = MB_W'(sel);
        mb_wr_id   = id;
        mb_wr_data = d;
        tick(1);
        wcyc     = cyc;
        mb_wr_en = 1'b0;
    endtask

    task automatic clr();
        send_cyc.delete(); send_id.delete(); send_data.delete(); send_mb.delete();
        done_cyc.delete(); done_vec.delete(); to_cyc.delete(); to_pend.delete();
        wr_err_cnt = 0;
    endtask

    task automatic wait_sends(input int n, input string tag);
        for (int i = 0; i < 300 && send_cyc.size() < n; i++) tick(1);
        check({tag, "_send_count"}, send_cyc.size(), n);
    endtask

    task automatic wait_dones(input int n, input string tag);
        for (int i = 0; i < 300 && done_cyc.size() < n; i++) tick(1);
        check({tag, "_done_count"}, done_cyc.size(), n);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pending"}, 32'(mb_pending), 0);
        check({tag, "_done"}, 32'(mb_done), 0);
        check({tag, "_wr_err"}, 32'(wr_err), 0);
        check({tag, "_timeout"}, 32'(timeout), 0);
        check({tag, "_can_id"}, 32'(can_id), 0);
        check({tag, "_can_data"}, 32'(can_data), 0);
        check({tag, "_can_send"}, 32'(can_send), 0);
        check({tag, "_cur_mb"}, 32'(cur_mb), 0);
        check({tag, "_arb_active"}, 32'(arb_active), 0);
    endtask

    initial begin
        int w;
        #1;
        check_all_zero("reset");
        tick(2);
        rst = 1'b0;
        tick(2);

        // Single frame.
        clr();
        wr(0, 11'h555, 8'hCC, w);
        wait_dones(1, "t1");
        check("t1_sends", send_cyc.size(), 1);
        check("t1_latency", send_cyc[0] - w, 2);
        check("t1_id", send_id[0], 32'h555);
        check("t1_data", send_data[0], 32'hCC);
        check("t1_done_vec", done_vec[0], 32'h1);
        check("t1_done_delay", done_cyc[0] - send_cyc[0], 42);
        check("t1_pending", 32'(mb_pending), 0);
        tick(3);

        // Priority: lower ID wins even though it was written later and sits at a higher index.
        clr();
        wr(1, 11'h300, 8'h11, w);
        wr(2, 11'h100, 8'h22, w);
        wait_dones(2, "t2");
        check("t2_sends", send_cyc.size(), 2);
        check("t2_first_id", send_id[0], 32'h100);
        check("t2_first_mb", send_mb[0], 2);
        check("t2_first_data", send_data[0], 32'h22);
        check("t2_second_id", send_id[1], 32'h300);
        check("t2_second_mb", send_mb[1], 1);
        check("t2_second_data", send_data[1], 32'h11);
        check("t2_done0", done_vec[0], 32'h4);
        check("t2_done1", done_vec[1], 32'h2);
        check("t2_gap", send_cyc[1] - done_cyc[0], 2);
        tick(3);

        // Tie on ID: index 0 wins; then mailbox 3 is aborted while mailbox 0 is in flight.
        clr();
        wr(3, 11'h0A0, 8'h33, w);
        wr(0, 11'h0A0, 8'h44, w);
        wait_sends(1, "t3");
        check("t3_mb", send_mb[0], 0);
        check("t3_data", send_data[0], 32'h44);
        tick(3);
        mb_abort = 4'b1000;
        tick(1);
        mb_abort = 4'b0000;
        check("t3_pending_after_abort", 32'(mb_pending), 32'h1);
        wait_dones(1, "t3");
        tick(10);
        check("t3_done_vec", done_vec[0], 32'h1);
        check("t3_no_done3", done_cyc.size(), 1);
        check("t3_sends", send_cyc.size(), 1);
        check("t3_pending", 32'(mb_pending), 0);

        // Write and abort aimed at the locked mailbox during WAIT_DONE are ignored.
        clr();
        wr(1, 11'h123, 8'h5A, w);
        wait_sends(1, "t4");
        tick(5);
        mb_wr_en   = 1'b1;
        mb_wr_sel  = 2'd1;
        mb_wr_id   = 11'h7FF;
        mb_wr_data = 8'hFF;
        mb_abort   = 4'b0010;
        tick(1);
        mb_wr_en = 1'b0;
        mb_abort = 4'b0000;
        wait_dones(1, "t4");
        tick(5);
        check("t4_wr_err_count", wr_err_cnt, 1);
        check("t4_done_vec", done_vec[0], 32'h2);
        check("t4_send_data", send_data[0], 32'h5A);
        check("t4_can_id_hold", 32'(can_id), 32'h123);
        check("t4_can_data_hold", 32'(can_data), 32'h5A);
        check("t4_sends", send_cyc.size(), 1);
        check("t4_pending", 32'(mb_pending), 0);

        // Engine never asserts busy: timeout, then re-arbitration of the same mailbox.
        clr();
        model_en = 0;
        wr(2, 11'h050, 8'h77, w);
        for (int i = 0; i < 100 && to_cyc.size() < 1; i++) tick(1);
        check("t5_timeout_seen", to_cyc.size(), 1);
        model_en = 1;
        wait_sends(2, "t5");
        wait_dones(1, "t5");
        check("t5_timeout_delay", to_cyc[0] - send_cyc[0], 16);
        check("t5_pending_at_timeout", to_pend[0], 32'h4);
        check("t5_relaunch_gap", send_cyc[1] - to_cyc[0], 2);
        check("t5_relaunch_id", send_id[1], 32'h050);
        check("t5_done_vec", done_vec[0], 32'h4);
        check("t5_timeouts", to_cyc.size(), 1);
        tick(3);

        // Asynchronous reset in the middle of a frame.
        clr();
        wr(1, 11'h3C3, 8'h99, w);
        wait_sends(1, "t6");
        wr(3, 11'h010, 8'h55, w);
        tick(4);
        check("t6_pending_pre", 32'(mb_pending), 32'hA);
        check("t6_cur_mb_pre", 32'(cur_mb), 1);
        check("t6_active_pre", 32'(arb_active), 1);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("t6_async");
        tick(2);
        rst = 1'b0;
        tick(60);
        check("t6_no_done", done_cyc.size(), 0);
        check("t6_sends", send_cyc.size(), 1);
        check("t6_pending_post", 32'(mb_pending), 0);
        check("t6_active_post", 32'(arb_active), 0);

        check("id_data_stability", stab_err, 0);
        check("send_while_busy", bad_send, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
